// File: rtl/decoder_nto2n_scan_pkg.sv
// Shared mode and FSM state encodings for the scanning N-to-2^N decoder.
// Pure definitions; no latency, no flow control.
package decoder_pkg;

  localparam logic [1:0] MODE_DIRECT  = 2'b00;
  localparam logic [1:0] MODE_SCAN_UP = 2'b01;
  localparam logic [1:0] MODE_SCAN_DN = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_DIRECT  = 3'd1,
    ST_SCAN_UP = 3'd2,
    ST_SCAN_DN = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  function automatic state_t mode_to_state(input logic [1:0] m);
    state_t s;
    case (m)
      MODE_DIRECT:  s = ST_DIRECT;
      MODE_SCAN_UP: s = ST_SCAN_UP;
      MODE_SCAN_DN: s = ST_SCAN_DN;
      default:      s = ST_HOLD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder with enable; zero latency.
// No flow control; all-zero output while i_en is low.
module dec_onehot #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      i_sel,
  input  logic                  i_en,
  output logic [2**SEL_W-1:0]   o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_sel] = 1'b1;
    end
  end

endmodule

// File: rtl/decoder_nto2n_scan.sv
// Registered one-hot decoder with direct-select and walking-one scan modes (programmable dwell).
// All outputs registered, 1 clk from inputs; no backpressure, a new decision every edge.
module decoder_nto2n_scan
  import decoder_pkg::*;
#(
  parameter int  SEL_W   = 3,
  parameter int  DWELL_W = 4,
  localparam int OUT_W   = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   out,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap,
  output logic               active
);

  state_t             r_state;
  state_t             w_nxt_state;
  state_t             r_resume_st;
  logic [SEL_W-1:0]   r_idx;
  logic [SEL_W-1:0]   w_idx_nxt;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_cnt_nxt;
  logic [OUT_W-1:0]   r_out;
  logic [OUT_W-1:0]   w_onehot;
  logic               r_wrap;
  logic               w_wrap_nxt;
  logic               r_active;
  logic               w_keep_cnt;

  // r_resume_st remembers the state that was running before HOLD was entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_OFF;
      r_resume_st <= ST_OFF;
    end else begin
      r_state <= w_nxt_state;
      if (r_state != ST_HOLD) begin
        r_resume_st <= r_state;
      end
    end
  end

  always_comb begin
    w_nxt_state = ST_OFF;
    if (en) begin
      w_nxt_state = mode_to_state(mode);
    end
  end

  // The dwell count survives staying put, entering HOLD, and returning from HOLD to the same scan.
  always_comb begin
    w_idx_nxt  = r_idx;
    w_cnt_nxt  = r_cnt;
    w_wrap_nxt = 1'b0;
    w_keep_cnt = (w_nxt_state == r_state) ||
                 (w_nxt_state == ST_HOLD) ||
                 ((r_state == ST_HOLD) && (w_nxt_state == r_resume_st));
    case (w_nxt_state)
      ST_DIRECT: begin
        w_idx_nxt = sel;
        w_cnt_nxt = '0;
      end
      ST_SCAN_UP, ST_SCAN_DN: begin
        if (load) begin
          w_idx_nxt = sel;
          w_cnt_nxt = '0;
        end else if (!w_keep_cnt) begin
          w_cnt_nxt = '0;
        end else if (r_cnt >= dwell) begin
          w_cnt_nxt = '0;
          if (w_nxt_state == ST_SCAN_UP) begin
            w_idx_nxt  = r_idx + SEL_W'(1);
            w_wrap_nxt = &r_idx;
          end else begin
            w_idx_nxt  = r_idx - SEL_W'(1);
            w_wrap_nxt = ~|r_idx;
          end
        end else begin
          w_cnt_nxt = r_cnt + DWELL_W'(1);
        end
      end
      ST_HOLD: begin
        w_cnt_nxt = r_cnt;
      end
      default: begin
        w_cnt_nxt = '0;
      end
    endcase
  end

  dec_onehot #(
    .SEL_W (SEL_W)
  ) u_dec (
    .i_sel    (w_idx_nxt),
    .i_en     (en),
    .o_onehot (w_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_wrap   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      r_out    <= w_onehot;
      r_wrap   <= w_wrap_nxt;
      r_active <= en;
    end
  end

  assign out    = r_out;
  assign idx    = r_idx;
  assign wrap   = r_wrap;
  assign active = r_active;

endmodule
